// File: rtl/gb_mmu.sv
// rtl/gb_mmu.sv - sm83 bus decode, internal VRAM/WRAM/OAM/HRAM, CPU tick strobe and OAM DMA engine.
// Everything runs on clk; CPU-visible state changes only on edges where cpu_ce=1.
module gb_mmu #(
  parameter int CPU_DIV = 4,
  parameter int VRAM_AW = 13,
  parameter int WRAM_AW = 13,
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        dma_active
);

  localparam int CW = $clog2(CPU_DIV);
  localparam logic [CW-1:0] CTR_LAST = CW'(CPU_DIV - 1);
  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} dma_state_t;

  logic [CW-1:0] r_ctr;
  dma_state_t    r_state, w_state_nxt;
  logic [7:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_dma_reg, w_dma_reg_nxt;

  logic [7:0] r_vram [0:(1<<VRAM_AW)-1];
  logic [7:0] r_wram [0:(1<<WRAM_AW)-1];
  logic [7:0] r_oam  [0:159];
  logic [7:0] r_hram [0:126];

  logic        w_cpu_rom, w_cpu_vram, w_cpu_wram, w_cpu_oam, w_cpu_dma_reg, w_cpu_hram;
  logic        w_cpu_we, w_dma_wr, w_copy;
  logic [15:0] w_src;
  logic [7:0]  w_src_data;

  always_ff @(posedge clk) begin
    if (rst || r_ctr == CTR_LAST) r_ctr <= '0;
    else                          r_ctr <= r_ctr + 1'b1;
  end

  assign cpu_ce = (r_ctr == CTR_LAST);

  assign w_cpu_rom     = ~cpu_addr[15];
  assign w_cpu_vram    = (cpu_addr[15:13] == 3'b100);
  assign w_cpu_wram    = (cpu_addr[15:13] == 3'b110) ||
                         (cpu_addr[15:13] == 3'b111 && cpu_addr < 16'hFE00);
  assign w_cpu_oam     = (cpu_addr >= 16'hFE00) && (cpu_addr < 16'hFEA0);
  assign w_cpu_dma_reg = (cpu_addr == 16'hFF46);
  assign w_cpu_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);

  assign dma_active = (r_state == S_XFER);
  assign w_src      = {r_dma_reg, r_idx};
  assign rom_addr   = dma_active ? w_src[14:0] : cpu_addr[14:0];

  assign w_dma_wr = !rst && cpu_ce && cpu_write && w_cpu_dma_reg;
  assign w_cpu_we = !rst && cpu_ce && cpu_write && (!dma_active || w_cpu_hram);
  assign w_copy   = !rst && cpu_ce && dma_active && !w_dma_wr;

  // Pages C0..FF all land in WRAM; for E0+ the echo offset only touches bits above WRAM_AW.
  always_comb begin
    w_src_data = 8'hFF;
    if (!w_src[15])                   w_src_data = rom_data;
    else if (w_src[15:13] == 3'b100)  w_src_data = r_vram[w_src[VRAM_AW-1:0]];
    else if (w_src[15:14] == 2'b11)   w_src_data = r_wram[w_src[WRAM_AW-1:0]];
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_dma_reg_nxt = r_dma_reg;
    if (w_dma_wr) begin
      w_dma_reg_nxt = cpu_wdata;
      w_idx_nxt     = 8'd0;
      w_state_nxt   = S_START;
    end else if (cpu_ce) begin
      case (r_state)
        S_START: w_state_nxt = S_XFER;
        S_XFER: begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt = r_idx + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 8'd0;
      r_dma_reg <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_dma_reg <= w_dma_reg_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cpu_we && w_cpu_vram) r_vram[cpu_addr[VRAM_AW-1:0]] <= cpu_wdata;
    if (w_cpu_we && w_cpu_wram) r_wram[cpu_addr[WRAM_AW-1:0]] <= cpu_wdata;
    if (w_cpu_we && w_cpu_hram) r_hram[cpu_addr[6:0]] <= cpu_wdata;
    if (w_copy)                      r_oam[r_idx] <= w_src_data;
    else if (w_cpu_we && w_cpu_oam)  r_oam[cpu_addr[7:0]] <= cpu_wdata;
  end

  always_comb begin
    cpu_rdata = 8'hFF;
    if (dma_active && !w_cpu_hram) cpu_rdata = 8'hFF;
    else if (w_cpu_rom)            cpu_rdata = rom_data;
    else if (w_cpu_vram)           cpu_rdata = r_vram[cpu_addr[VRAM_AW-1:0]];
    else if (w_cpu_wram)           cpu_rdata = r_wram[cpu_addr[WRAM_AW-1:0]];
    else if (w_cpu_oam)            cpu_rdata = r_oam[cpu_addr[7:0]];
    else if (w_cpu_dma_reg)        cpu_rdata = r_dma_reg;
    else if (w_cpu_hram)           cpu_rdata = r_hram[cpu_addr[6:0]];
  end

endmodule
